// File: rtl/hgcal_fc_codes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hgcal_fc_codes_pkg
// Description : Fast-control code table, command and receiver-state enums
//               for the HGCAL fast-control link. Shared by the encoder
//               (single-shot manager) and the decoder.
// Contents    : C_CODE_* 8-bit line codes, fc_cmd_e, fc_state_e,
//               fc_decode() / fc_encode() helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hgcal_fc_codes_pkg;

    // Line codes. No rotation of IDLE equals IDLE, so the word boundary
    // found by searching for IDLE is unique.
    localparam logic [7:0] C_CODE_IDLE         = 8'hAC;
    localparam logic [7:0] C_CODE_L1A          = 8'h4B;
    localparam logic [7:0] C_CODE_BCR          = 8'h5A;
    localparam logic [7:0] C_CODE_OCR          = 8'h2D;
    localparam logic [7:0] C_CODE_LINK_RESET   = 8'h78;
    localparam logic [7:0] C_CODE_CALPULSE_INT = 8'h66;
    localparam logic [7:0] C_CODE_CALPULSE_EXT = 8'h99;

    typedef enum logic [2:0] {
        CMD_IDLE       = 3'd0,
        CMD_L1A        = 3'd1,
        CMD_BCR        = 3'd2,
        CMD_OCR        = 3'd3,
        CMD_LINK_RESET = 3'd4,
        CMD_CAL_INT    = 3'd5,
        CMD_CAL_EXT    = 3'd6,
        CMD_INVALID    = 3'd7
    } fc_cmd_e;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } fc_state_e;

    // Map an aligned 8-bit word to a command; anything off-table is INVALID.
    function automatic fc_cmd_e fc_decode(input logic [7:0] word);
        fc_cmd_e cmd;
        case (word)
            C_CODE_IDLE:         cmd = CMD_IDLE;
            C_CODE_L1A:          cmd = CMD_L1A;
            C_CODE_BCR:          cmd = CMD_BCR;
            C_CODE_OCR:          cmd = CMD_OCR;
            C_CODE_LINK_RESET:   cmd = CMD_LINK_RESET;
            C_CODE_CALPULSE_INT: cmd = CMD_CAL_INT;
            C_CODE_CALPULSE_EXT: cmd = CMD_CAL_EXT;
            default:             cmd = CMD_INVALID;
        endcase
        return cmd;
    endfunction

    // Encoder-side inverse; INVALID is sent as IDLE.
    function automatic logic [7:0] fc_encode(input fc_cmd_e cmd);
        logic [7:0] word;
        case (cmd)
            CMD_L1A:        word = C_CODE_L1A;
            CMD_BCR:        word = C_CODE_BCR;
            CMD_OCR:        word = C_CODE_OCR;
            CMD_LINK_RESET: word = C_CODE_LINK_RESET;
            CMD_CAL_INT:    word = C_CODE_CALPULSE_INT;
            CMD_CAL_EXT:    word = C_CODE_CALPULSE_EXT;
            default:        word = C_CODE_IDLE;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hgcal_fc_word_align.sv
`default_nettype none
// ============================================================================
// Module      : hgcal_fc_word_align
// Description : Word aligner. Holds the previous raw word and selects the
//               8-bit aligned word out of the 16-bit window
//               {prev_word, rx_word} at bit offset phase.
// Ports       : clk40   - 40 MHz BX clock
//               reset   - asynchronous active-high reset
//               rx_word - raw deserialised word (arbitrary bit phase)
//               phase   - alignment offset 0..7 (0 = rx_word unchanged)
//               aligned - aligned word (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module hgcal_fc_word_align (
    input  logic       clk40,
    input  logic       reset,
    input  logic [7:0] rx_word,
    input  logic [2:0] phase,
    output logic [7:0] aligned
);

    logic [7:0]  r_prev_word;
    logic [15:0] w_window;

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_prev_word <= 8'h00;
        end else begin
            r_prev_word <= rx_word;
        end
    end

    assign w_window = {r_prev_word, rx_word};

    // Zero-extended index keeps the select base as wide as the window
    // address; the highest offset (7) still lands inside the window.
    assign aligned = w_window[{1'b0, phase} +: 8];

endmodule
`default_nettype wire

// File: rtl/hgcal_fc_decoder_single_shot.sv
`default_nettype none
// ============================================================================
// Module      : hgcal_fc_decoder_single_shot
// Description : Fast-control receiver. Searches the 8-bit/BX stream for the
//               IDLE word boundary, confirms it over LOCK_COUNT consecutive
//               IDLEs, then decodes each aligned word into one-cycle command
//               pulses and counts invalid words.
// Ports       : clk40            - 40 MHz BX clock
//               reset            - asynchronous active-high reset
//               rx_word[7:0]     - raw deserialised word
//               err_clear        - synchronous clear of err_count
//               locked           - high while LOCKED
//               phase[2:0]       - current alignment offset
//               cmd_*            - one-cycle command pulses (latency 1)
//               cmd_invalid      - invalid word seen while LOCKED
//               err_count[ERR_W] - saturating invalid-word counter
// Revision    : 1.0 - initial release
// ============================================================================
module hgcal_fc_decoder_single_shot
    import hgcal_fc_codes_pkg::*;
#(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERR_W        = 16
) (
    input  logic             clk40,
    input  logic             reset,
    input  logic [7:0]       rx_word,
    input  logic             err_clear,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             cmd_l1a,
    output logic             cmd_bcr,
    output logic             cmd_ocr,
    output logic             cmd_link_reset,
    output logic             cmd_calpulse_int,
    output logic             cmd_calpulse_ext,
    output logic             cmd_invalid,
    output logic [ERR_W-1:0] err_count
);

    localparam int C_IDLE_W = $clog2(LOCK_COUNT + 1);
    localparam int C_BAD_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [C_IDLE_W-1:0] C_LOCK_TARGET   = C_IDLE_W'(LOCK_COUNT);
    localparam logic [C_BAD_W-1:0]  C_UNLOCK_TARGET = C_BAD_W'(UNLOCK_COUNT);

    fc_state_e           r_state;
    logic [2:0]          r_phase;
    logic [C_IDLE_W-1:0] r_idle_cnt;
    logic [C_BAD_W-1:0]  r_bad_cnt;
    logic [ERR_W-1:0]    r_err_count;
    logic                r_locked;
    logic                r_cmd_l1a;
    logic                r_cmd_bcr;
    logic                r_cmd_ocr;
    logic                r_cmd_link_reset;
    logic                r_cmd_cal_int;
    logic                r_cmd_cal_ext;
    logic                r_cmd_invalid;

    logic [7:0]          w_aligned;
    fc_cmd_e             w_cmd;
    logic [C_IDLE_W-1:0] w_idle_inc;
    logic [C_BAD_W-1:0]  w_bad_inc;
    logic                w_count_err;

    hgcal_fc_word_align u_word_align (
        .clk40   (clk40),
        .reset   (reset),
        .rx_word (rx_word),
        .phase   (r_phase),
        .aligned (w_aligned)
    );

    assign w_cmd       = fc_decode(w_aligned);
    assign w_idle_inc  = r_idle_cnt + C_IDLE_W'(1);
    assign w_bad_inc   = r_bad_cnt + C_BAD_W'(1);
    assign w_count_err = (r_state == ST_LOCKED) && (w_cmd == CMD_INVALID);

    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_state          <= ST_SEARCH;
            r_phase          <= 3'd0;
            r_idle_cnt       <= '0;
            r_bad_cnt        <= '0;
            r_locked         <= 1'b0;
            r_cmd_l1a        <= 1'b0;
            r_cmd_bcr        <= 1'b0;
            r_cmd_ocr        <= 1'b0;
            r_cmd_link_reset <= 1'b0;
            r_cmd_cal_int    <= 1'b0;
            r_cmd_cal_ext    <= 1'b0;
            r_cmd_invalid    <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-armed below by this word.
            r_cmd_l1a        <= 1'b0;
            r_cmd_bcr        <= 1'b0;
            r_cmd_ocr        <= 1'b0;
            r_cmd_link_reset <= 1'b0;
            r_cmd_cal_int    <= 1'b0;
            r_cmd_cal_ext    <= 1'b0;
            r_cmd_invalid    <= 1'b0;

            case (r_state)
                ST_SEARCH: begin
                    if (w_cmd == CMD_IDLE) begin
                        r_state    <= ST_CONFIRM;
                        r_idle_cnt <= C_IDLE_W'(1);
                    end else begin
                        r_phase <= r_phase + 3'd1;
                    end
                end

                ST_CONFIRM: begin
                    if (w_cmd == CMD_IDLE) begin
                        if (w_idle_inc == C_LOCK_TARGET) begin
                            r_state    <= ST_LOCKED;
                            r_locked   <= 1'b1;
                            r_bad_cnt  <= '0;
                            r_idle_cnt <= '0;
                        end else begin
                            r_idle_cnt <= w_idle_inc;
                        end
                    end else begin
                        // A valid command here means the boundary is wrong
                        // or the link is not yet quiet: restart the search.
                        r_state    <= ST_SEARCH;
                        r_phase    <= r_phase + 3'd1;
                        r_idle_cnt <= '0;
                    end
                end

                ST_LOCKED: begin
                    case (w_cmd)
                        CMD_L1A:        r_cmd_l1a        <= 1'b1;
                        CMD_BCR:        r_cmd_bcr        <= 1'b1;
                        CMD_OCR:        r_cmd_ocr        <= 1'b1;
                        CMD_LINK_RESET: r_cmd_link_reset <= 1'b1;
                        CMD_CAL_INT:    r_cmd_cal_int    <= 1'b1;
                        CMD_CAL_EXT:    r_cmd_cal_ext    <= 1'b1;
                        default: ;
                    endcase

                    if (w_cmd == CMD_INVALID) begin
                        r_cmd_invalid <= 1'b1;
                        if (w_bad_inc == C_UNLOCK_TARGET) begin
                            // Phase is kept: the search resumes from the
                            // last known boundary.
                            r_state   <= ST_SEARCH;
                            r_locked  <= 1'b0;
                            r_bad_cnt <= '0;
                        end else begin
                            r_bad_cnt <= w_bad_inc;
                        end
                    end else begin
                        r_bad_cnt <= '0;
                    end
                end

                default: begin
                    r_state    <= ST_SEARCH;
                    r_locked   <= 1'b0;
                    r_idle_cnt <= '0;
                    r_bad_cnt  <= '0;
                end
            endcase
        end
    end

    // Error counter: clear has priority over a coincident invalid word.
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (err_clear) begin
            r_err_count <= '0;
        end else if (w_count_err && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign locked           = r_locked;
    assign phase            = r_phase;
    assign cmd_l1a          = r_cmd_l1a;
    assign cmd_bcr          = r_cmd_bcr;
    assign cmd_ocr          = r_cmd_ocr;
    assign cmd_link_reset   = r_cmd_link_reset;
    assign cmd_calpulse_int = r_cmd_cal_int;
    assign cmd_calpulse_ext = r_cmd_cal_ext;
    assign cmd_invalid      = r_cmd_invalid;
    assign err_count        = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_hgcal_fc_decoder_single_shot.sv
`default_nettype none
// ============================================================================
// Module      : tb_hgcal_fc_decoder_single_shot
// Description : Scoreboard bench for the fast-control decoder. A driver
//               applies words on the falling edge and pushes the expected
//               post-edge outputs from a bit-window reference model; a
//               monitor pops and compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hgcal_fc_decoder_single_shot;

    localparam int LOCK   = 16;
    localparam int UNLOCK = 4;
    localparam int ERRW   = 4;
    localparam int ERRMAX = (1 << ERRW) - 1;

    typedef struct packed {
        logic            locked;
        logic [2:0]      phase;
        logic [6:0]      cmds;   // {l1a,bcr,ocr,link_reset,cal_int,cal_ext,invalid}
        logic [ERRW-1:0] err;
    } obs_t;

    logic            clk40 = 1'b0;
    logic            reset;
    logic [7:0]      rx_word;
    logic            err_clear;
    logic            locked;
    logic [2:0]      phase;
    logic            cmd_l1a, cmd_bcr, cmd_ocr, cmd_link_reset;
    logic            cmd_calpulse_int, cmd_calpulse_ext, cmd_invalid;
    logic [ERRW-1:0] err_count;

    int checks   = 0;
    int failures = 0;

    obs_t exp_q[$];

    hgcal_fc_decoder_single_shot #(
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK),
        .ERR_W        (ERRW)
    ) dut (
        .clk40            (clk40),
        .reset            (reset),
        .rx_word          (rx_word),
        .err_clear        (err_clear),
        .locked           (locked),
        .phase            (phase),
        .cmd_l1a          (cmd_l1a),
        .cmd_bcr          (cmd_bcr),
        .cmd_ocr          (cmd_ocr),
        .cmd_link_reset   (cmd_link_reset),
        .cmd_calpulse_int (cmd_calpulse_int),
        .cmd_calpulse_ext (cmd_calpulse_ext),
        .cmd_invalid      (cmd_invalid),
        .err_count        (err_count)
    );

    always #5 clk40 = ~clk40;

    // ---------------- reference model ----------------
    // Code table index: 0 = IDLE, 1..6 = commands in pulse order, -1 = invalid.
    logic [7:0] codes [7] = '{8'hAC, 8'h4B, 8'h5A, 8'h2D, 8'h78, 8'h66, 8'h99};

    int         m_state;  // 0 search, 1 confirm, 2 locked
    int         m_phase;
    logic [7:0] m_prev;
    int         m_idles;
    int         m_bads;
    int         m_err;

    function automatic int code_index(input logic [7:0] w);
        for (int i = 0; i < 7; i++) if (codes[i] == w) return i;
        return -1;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] rand_invalid();
        logic [7:0] w;
        do w = 8'($urandom_range(0, 255)); while (code_index(w) >= 0);
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_prev = 8'h00;
        m_idles = 0; m_bads = 0; m_err = 0;
    endtask

    function automatic obs_t model_step(input logic [7:0] w, input logic clr);
        obs_t        e;
        logic [15:0] window;
        int          idx;
        window = {m_prev, w};
        idx    = code_index(8'((window >> m_phase) & 16'h00FF));
        e.cmds = '0;
        if (m_state == 2) begin
            if (idx < 0) begin
                e.cmds[0] = 1'b1;
                m_bads++;
                if (m_err < ERRMAX) m_err++;
                if (m_bads == UNLOCK) begin m_state = 0; m_bads = 0; end
            end else begin
                m_bads = 0;
                if (idx > 0) e.cmds[7 - idx] = 1'b1;
            end
        end else if (m_state == 0) begin
            if (idx == 0) begin m_state = 1; m_idles = 1; end
            else m_phase = (m_phase + 1) % 8;
        end else begin
            if (idx == 0) begin
                m_idles++;
                if (m_idles == LOCK) begin m_state = 2; m_bads = 0; end
            end else begin
                m_state = 0; m_phase = (m_phase + 1) % 8; m_idles = 0;
            end
        end
        if (clr) m_err = 0;
        m_prev   = w;
        e.locked = (m_state == 2);
        e.phase  = 3'(m_phase);
        e.err    = ERRW'(m_err);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.locked = locked;
        o.phase  = phase;
        o.cmds   = {cmd_l1a, cmd_bcr, cmd_ocr, cmd_link_reset,
                    cmd_calpulse_int, cmd_calpulse_ext, cmd_invalid};
        o.err    = err_count;
        return o;
    endfunction

    // ---------------- driver helpers (entered at a falling edge) ----------------
    task automatic drive(input logic [7:0] w, input logic clr = 1'b0);
        rx_word   = w;
        err_clear = clr;
        exp_q.push_back(model_step(w, clr));
        @(negedge clk40);
    endtask

    task automatic apply_reset();
        reset = 1'b1; rx_word = 8'h00; err_clear = 1'b0;
        exp_q.delete();
        @(negedge clk40);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic drive_idles(input int n);
        for (int i = 0; i < n; i++) drive(8'hAC);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk40);
            #2;
            if (!reset && exp_q.size() > 0) begin
                obs_t e, g;
                e = exp_q.pop_front();
                g = observe();
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got lk=%0b ph=%0d cmd=%07b err=%0d expected lk=%0b ph=%0d cmd=%07b err=%0d",
                             $time, g.locked, g.phase, g.cmds, g.err,
                             e.locked, e.phase, e.cmds, e.err);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [7:0] cmd_list [6] = '{8'h4B, 8'h5A, 8'h2D, 8'h78, 8'h66, 8'h99};

    initial begin
        reset = 1'b1; rx_word = 8'h00; err_clear = 1'b0;
        model_reset();
        #1;
        check("reset_state", 32'(observe()), 32'h0);
        @(negedge clk40);
        reset = 1'b0;

        // Constant IDLE rotated so that only phase 3 aligns it.
        for (int i = 0; i < 24; i++) drive(rotl8(8'hAC, 3));
        check("lock_phase3", {28'h0, locked, phase}, {28'h0, 1'b1, 3'd3});

        // Each command surrounded by IDLEs at phase 0, plus back-to-back L1A.
        apply_reset();
        drive_idles(18);
        for (int i = 0; i < 6; i++) begin
            drive(cmd_list[i]);
            drive_idles(2);
        end
        drive(8'h4B); drive(8'h4B); drive(8'h4B);
        drive_idles(2);

        // Error groups: 3 invalid (stay locked), IDLE, 4 invalid (unlock).
        for (int i = 0; i < 3; i++) drive(8'h00);
        check("err_after_3", {27'h0, locked, err_count}, {27'h0, 1'b1, 4'd3});
        drive(8'hAC);
        for (int i = 0; i < 4; i++) drive(8'h00);
        check("err_after_7", {27'h0, locked, err_count}, {27'h0, 1'b0, 4'd7});
        drive_idles(4);

        // L1A during confirmation aborts acquisition without a pulse.
        apply_reset();
        drive_idles(10);
        drive(8'h4B);
        check("confirm_abort", {28'h0, locked, phase}, {28'h0, 1'b0, 3'd1});
        drive_idles(4);

        // Saturation of the narrow counter, then clear racing an invalid word.
        apply_reset();
        drive_idles(17);
        for (int i = 0; i < 20; i++) begin
            drive(rand_invalid());
            drive(8'hAC);
        end
        check("err_saturated", 32'(err_count), 32'(ERRMAX));
        drive(rand_invalid(), 1'b1);
        check("clear_wins", {27'h0, cmd_invalid, err_count}, {27'h0, 1'b1, 4'd0});
        drive_idles(2);

        // Random phase acquisition.
        for (int k = 0; k < 6; k++) begin
            int p = $urandom_range(0, 7);
            apply_reset();
            for (int i = 0; i < 30; i++) drive(rotl8(8'hAC, p));
            check("rand_lock_phase", {28'h0, locked, phase}, {28'h0, 1'b1, 3'(p)});
        end

        // Random traffic at phase 0: IDLE, commands, garbage, occasional clear.
        apply_reset();
        drive_idles(17);
        for (int i = 0; i < 600; i++) begin
            int         r = $urandom_range(0, 99);
            logic [7:0] w;
            if (r < 55)      w = 8'hAC;
            else if (r < 85) w = cmd_list[$urandom_range(0, 5)];
            else             w = rand_invalid();
            drive(w, ($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset while locked with an L1A pulse high.
        apply_reset();
        drive_idles(17);
        drive(8'h00);
        drive(8'h4B);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset", 32'(observe()), 32'h0);
        model_reset();
        @(negedge clk40);
        reset = 1'b0;
        drive_idles(20);
        check("relock", {28'h0, locked, phase}, {28'h0, 1'b1, 3'd0});

        @(posedge clk40);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hgcal_fc_decoder_single_shot.md
Name: hgcal_fc_decoder_single_shot

Overview:
- Receive-side counterpart of the fast-control single-shot manager.
- Takes the deserialised 8-bit-per-BX fast-control stream at 40 MHz and recovers the word boundary by searching for the IDLE pattern.
- Once locked, decodes each aligned word into one-cycle command pulses and counts code errors.
- Sits between the link deserialiser and the front-end trigger/calibration logic.

Parameters:
- LOCK_COUNT, 16: consecutive aligned IDLE words required to declare lock (≥2).
- UNLOCK_COUNT, 4: consecutive invalid words in LOCKED that force a return to SEARCH (≥1).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk40  input  1  40 MHz BX clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_word  input  8  raw deserialised word, one per clk40, arbitrary bit phase.
- err_clear  input  1  synchronous clear of err_count.
- locked  output  1  high while state is LOCKED.
- phase  output  3  current alignment offset.
- cmd_l1a  output  1  one-cycle pulse.
- cmd_bcr  output  1  one-cycle pulse.
- cmd_ocr  output  1  one-cycle pulse.
- cmd_link_reset  output  1  one-cycle pulse.
- cmd_calpulse_int  output  1  one-cycle pulse.
- cmd_calpulse_ext  output  1  one-cycle pulse.
- cmd_invalid  output  1  one-cycle pulse on an invalid word while LOCKED.
- err_count  output  ERR_W  saturating count of invalid words seen while LOCKED.

Behaviour:
- Reset state: all outputs 0, state SEARCH, phase 0, prev_word 0, idle_cnt 0, bad_cnt 0.
- Alignment:
  - prev_word <= rx_word every cycle.
  - window = {prev_word, rx_word}.
  - aligned = window[phase+7 : phase]; phase 0 selects rx_word unchanged.
- Code table (package constants): IDLE 8'hAC, L1A 8'h4B, BCR 8'h5A, OCR 8'h2D, LINK_RESET 8'h78, CALPULSE_INT 8'h66, CALPULSE_EXT 8'h99.
  - Any other value is invalid.
  - No rotation of IDLE equals IDLE, so alignment is unique.
- State machine, evaluated on aligned each cycle:
  - SEARCH:
    - aligned==IDLE -> CONFIRM, idle_cnt=1.
    - Otherwise phase <= phase+1 (wraps 7->0), stay in SEARCH.
  - CONFIRM:
    - aligned==IDLE: idle_cnt+1. When the incremented count reaches LOCK_COUNT -> LOCKED, bad_cnt=0.
    - Any non-IDLE word, valid code or not -> SEARCH, phase <= phase+1, idle_cnt=0.
  - LOCKED:
    - Valid code: bad_cnt=0.
    - Invalid word: bad_cnt+1, cmd_invalid pulses, err_count increments (saturating at all-ones).
    - When the incremented bad_cnt reaches UNLOCK_COUNT -> SEARCH, phase unchanged, locked drops the following cycle.
- Pulse outputs:
  - Registered; each asserts for exactly one cycle, in the cycle after the rx_word that completed the aligned code was presented (latency 1).
  - Only asserted while the state is LOCKED when the word is evaluated.
  - IDLE produces no pulse.
  - Back-to-back identical commands give back-to-back pulses with no merging.
- locked: registered from the state; rises 1 cycle after the LOCK_COUNT-th IDLE is evaluated.
- err_clear: zeroes err_count next cycle. If it coincides with an invalid word, clear wins and err_count=0; cmd_invalid still pulses.
- Reset asserted mid-operation clears everything immediately, pulses included.
- After release, lock is reacquired from SEARCH at phase 0.

Decomposition:
- Package hgcal_fc_codes_pkg holds:
  - the 8-bit code constants;
  - a command enum (IDLE, L1A, BCR, OCR, LINK_RESET, CAL_INT, CAL_EXT, INVALID);
  - the state enum (SEARCH, CONFIRM, LOCKED).
- The package is shared with the encoder side.
- One sub-module, hgcal_fc_word_align: prev_word register plus the 16->8 barrel select driven by phase (purely datapath).
- The FSM, decode and counters stay in the top module.

Test Plan:
- Continuous IDLE stream shifted to require phase 3:
  - phase stepping 0,1,2 then holds 3;
  - locked=1 one cycle after 16 consecutive aligned IDLEs (LOCK_COUNT=16);
  - no cmd_* pulses during acquisition.
- Locked at phase 0, inject 4B, 5A, 2D, 78, 66, 99 each surrounded by IDLEs:
  - exactly one cycle each on cmd_l1a, cmd_bcr, cmd_ocr, cmd_link_reset, cmd_calpulse_int, cmd_calpulse_ext;
  - each pulse 1 cycle after its word.
- Locked, 3 words of 8'h00 then IDLE, then 4 words of 8'h00:
  - err_count=3 after the first group, locked stays 1;
  - err_count=7 after the second group and locked=0 (state SEARCH).
- In CONFIRM after 10 IDLEs, inject 8'h4B:
  - returns to SEARCH with phase incremented;
  - no cmd_l1a pulse.
- With ERR_W=4: 20 isolated invalid words separated by IDLEs -> err_count saturates at 15. Then err_clear together with an invalid word -> err_count=0 and cmd_invalid=1.
- Assert reset asynchronously while locked and mid-command:
  - locked, phase, err_count and all pulses go 0 immediately;
  - relock succeeds after release.
